// File: rtl/mem_pkg.sv
// Shared opcode constants, FSM state encoding and decode helpers
// for the data-memory load/store path.
package mem_pkg;

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2B;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2,
    ST_WB   = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } size_e;

  function automatic logic is_load(input logic [5:0] op);
    return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
           (op == OP_LBU) || (op == OP_LHU);
  endfunction

  function automatic logic is_store(input logic [5:0] op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  function automatic logic is_legal(input logic [5:0] op);
    return is_load(op) || is_store(op);
  endfunction

  function automatic size_e op_size(input logic [5:0] op);
    size_e sz;
    case (op)
      OP_LB, OP_LBU, OP_SB: sz = SZ_B;
      OP_LH, OP_LHU, OP_SH: sz = SZ_H;
      default:              sz = SZ_W;
    endcase
    return sz;
  endfunction

  function automatic logic misaligned(input logic [5:0] op, input logic [1:0] a);
    logic bad;
    case (op_size(op))
      SZ_H:    bad = a[0];
      SZ_W:    bad = (a != 2'b00);
      default: bad = 1'b0;
    endcase
    return bad;
  endfunction

  function automatic logic [3:0] lane_be(input size_e sz, input logic [1:0] a);
    logic [3:0] be;
    case (sz)
      SZ_B:    be = 4'b0001 << a;
      SZ_H:    be = a[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  // Replicate the right-aligned store operand into every lane it could occupy.
  function automatic logic [31:0] lane_wdata(input size_e sz, input logic [31:0] d);
    logic [31:0] w;
    case (sz)
      SZ_B:    w = {4{d[7:0]}};
      SZ_H:    w = {2{d[15:0]}};
      default: w = d;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/load_extend.sv
// Combinational load-data aligner: picks the addressed byte/halfword out
// of the read word and sign- or zero-extends it.
module load_extend
  import mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [5:0]  opcode,
  output logic [31:0] wb_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[{addr_lo, 3'b000} +: 8];
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (opcode)
      OP_LB:   wb_data = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU:  wb_data = {24'd0, byte_sel};
      OP_LH:   wb_data = {{16{half_sel[15]}}, half_sel};
      OP_LHU:  wb_data = {16'd0, half_sel};
      default: wb_data = rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory initiator: turns one EX-stage load/store into a byte-lane
// memory request, waits for grant/read data, and returns extended load data.
module load_store_unit
  import mem_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [5:0]        ex_opcode,
  input  logic [ADDR_W-1:0] ex_addr,
  input  logic [31:0]       ex_wdata,
  input  logic [4:0]        ex_rt,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata,
  output logic              wb_valid,
  output logic [4:0]        wb_rd,
  output logic [31:0]       wb_data,
  output logic              done,
  output logic              err
);

  state_e            state_q, state_d;
  logic [5:0]        op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [4:0]        rt_q, rt_d;
  logic [3:0]        be_q, be_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;
  logic              done_q, done_d;

  logic [CNT_W-1:0]  cnt_inc;
  logic              timeout_hit;
  logic [31:0]       ext_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      addr_q  <= '0;
      rt_q    <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      rt_q    <= rt_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    addr_d      = addr_q;
    rt_d        = rt_q;
    be_d        = be_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    cnt_d       = cnt_q;
    err_d       = 1'b0;
    done_d      = 1'b0;
    cnt_inc     = cnt_q + 1'b1;
    timeout_hit = (cnt_inc == CNT_W'(TIMEOUT));

    case (state_q)
      ST_IDLE: begin
        if (ex_valid) begin
          op_d    = ex_opcode;
          addr_d  = ex_addr;
          rt_d    = ex_rt;
          be_d    = lane_be(op_size(ex_opcode), ex_addr[1:0]);
          wdata_d = lane_wdata(op_size(ex_opcode), ex_wdata);
          if (!is_legal(ex_opcode) || misaligned(ex_opcode, ex_addr[1:0])) begin
            err_d = 1'b1;
          end else begin
            state_d = ST_REQ;
            cnt_d   = '0;
          end
        end
      end
      ST_REQ: begin
        if (mem_gnt) begin
          cnt_d = '0;
          if (is_load(op_q)) begin
            // Read data may arrive together with the grant; skip RESP then.
            if (mem_rvalid) begin
              rdata_d = mem_rdata;
              state_d = ST_WB;
            end else begin
              state_d = ST_RESP;
            end
          end else begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end
        end else if (timeout_hit) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_RESP: begin
        if (mem_rvalid) begin
          rdata_d = mem_rdata;
          state_d = ST_WB;
        end else if (timeout_hit) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_WB: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  load_extend u_load_extend (
    .rdata   (rdata_q),
    .addr_lo (addr_q[1:0]),
    .opcode  (op_q),
    .wb_data (ext_data)
  );

  // Memory payload is held at zero outside REQ so the port is quiet when idle.
  always_comb begin
    ex_ready  = (state_q == ST_IDLE);
    mem_req   = (state_q == ST_REQ);
    mem_we    = mem_req && is_store(op_q);
    mem_addr  = mem_req ? addr_q[ADDR_W-1:2] : '0;
    mem_be    = mem_req ? be_q : 4'b0000;
    mem_wdata = mem_req ? wdata_q : 32'd0;
    wb_valid  = (state_q == ST_WB);
    wb_rd     = wb_valid ? rt_q : 5'd0;
    wb_data   = wb_valid ? ext_data : 32'd0;
    done      = wb_valid || done_q;
    err       = err_q;
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: loads, stores, misalignment,
// timeout and mid-transaction reset, with hand-computed expectations.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_valid;
  logic        ex_ready;
  logic [5:0]  ex_opcode;
  logic [31:0] ex_addr;
  logic [31:0] ex_wdata;
  logic [4:0]  ex_rt;
  logic        mem_req;
  logic        mem_we;
  logic [29:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        done;
  logic        err;

  int checks_total  = 0;
  int checks_passed = 0;

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_W(32), .TIMEOUT(16), .CNT_W(5)) dut (
    .clk        (clk),
    .reset      (reset),
    .ex_valid   (ex_valid),
    .ex_ready   (ex_ready),
    .ex_opcode  (ex_opcode),
    .ex_addr    (ex_addr),
    .ex_wdata   (ex_wdata),
    .ex_rt      (ex_rt),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_be     (mem_be),
    .mem_wdata  (mem_wdata),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .wb_valid   (wb_valid),
    .wb_rd      (wb_rd),
    .wb_data    (wb_data),
    .done       (done),
    .err        (err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_total++;
    assert (obs === exp) checks_passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic present(input logic [5:0] op, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [4:0] rt);
    ex_valid  = 1'b1;
    ex_opcode = op;
    ex_addr   = addr;
    ex_wdata  = wdata;
    ex_rt     = rt;
  endtask

  // Zero-wait load: grant in the first REQ cycle, rvalid the cycle after.
  task automatic do_load(input string name, input logic [5:0] op, input logic [31:0] addr,
                         input logic [4:0] rt, input logic [31:0] rdata,
                         input logic [29:0] exp_waddr, input logic [3:0] exp_be,
                         input logic [31:0] exp_data);
    present(op, addr, 32'd0, rt);
    tick();
    ex_valid = 1'b0;
    check({name, ".req"},    32'(mem_req), 32'd1);
    check({name, ".we"},     32'(mem_we), 32'd0);
    check({name, ".addr"},   32'(mem_addr), 32'(exp_waddr));
    check({name, ".be"},     32'(mem_be), 32'(exp_be));
    check({name, ".ready"},  32'(ex_ready), 32'd0);
    mem_gnt = 1'b1;
    tick();
    mem_gnt    = 1'b0;
    check({name, ".resp_wb"}, 32'(wb_valid), 32'd0);
    check({name, ".resp_req"}, 32'(mem_req), 32'd0);
    mem_rvalid = 1'b1;
    mem_rdata  = rdata;
    tick();
    mem_rvalid = 1'b0;
    mem_rdata  = 32'd0;
    check({name, ".wb_valid"}, 32'(wb_valid), 32'd1);
    check({name, ".wb_data"},  wb_data, exp_data);
    check({name, ".wb_rd"},    32'(wb_rd), 32'(rt));
    check({name, ".done"},     32'(done), 32'd1);
    tick();
    check({name, ".wb_drop"},  32'(wb_valid), 32'd0);
    check({name, ".done_drop"}, 32'(done), 32'd0);
    check({name, ".ready"},    32'(ex_ready), 32'd1);
    $display("txn %s op=%h addr=%h wb_data=%h", name, op, addr, wb_data);
  endtask

  task automatic do_bad(input string name, input logic [5:0] op, input logic [31:0] addr);
    present(op, addr, 32'd0, 5'd1);
    tick();
    ex_valid = 1'b0;
    check({name, ".err"},   32'(err), 32'd1);
    check({name, ".req"},   32'(mem_req), 32'd0);
    check({name, ".ready"}, 32'(ex_ready), 32'd1);
    tick();
    check({name, ".err_drop"}, 32'(err), 32'd0);
    check({name, ".req2"},  32'(mem_req), 32'd0);
    $display("txn %s op=%h addr=%h rejected", name, op, addr);
  endtask

  initial begin
    reset      = 1'b1;
    ex_valid   = 1'b0;
    ex_opcode  = 6'd0;
    ex_addr    = 32'd0;
    ex_wdata   = 32'd0;
    ex_rt      = 5'd0;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = 32'd0;
    tick();
    tick();
    check("rst.ready", 32'(ex_ready), 32'd1);
    check("rst.req",   32'(mem_req), 32'd0);
    check("rst.wb",    32'(wb_valid), 32'd0);
    check("rst.done",  32'(done), 32'd0);
    check("rst.err",   32'(err), 32'd0);
    reset = 1'b0;
    tick();

    // lw, word address 0x4, full lanes
    do_load("lw", 6'h23, 32'h10, 5'd7, 32'hDEADBEEF, 30'h4, 4'b1111, 32'hDEADBEEF);
    // byte 3 of 0x80112233 is 0x80
    do_load("lb", 6'h20, 32'h13, 5'd9, 32'h80112233, 30'h4, 4'b1000, 32'hFFFFFF80);
    do_load("lbu", 6'h24, 32'h13, 5'd10, 32'h80112233, 30'h4, 4'b1000, 32'h00000080);
    do_load("lh", 6'h21, 32'h20, 5'd11, 32'h1234F00D, 30'h8, 4'b0011, 32'hFFFFF00D);

    // lhu with rvalid in the same cycle as gnt: REQ -> WB, 2-cycle latency
    present(6'h25, 32'h02, 32'd0, 5'd12);
    tick();
    ex_valid   = 1'b0;
    check("lhu_fast.be", 32'(mem_be), 32'(4'b1100));
    mem_gnt    = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h80011234;
    tick();
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    check("lhu_fast.wb_valid", 32'(wb_valid), 32'd1);
    check("lhu_fast.wb_data",  wb_data, 32'h00008001);
    check("lhu_fast.wb_rd",    32'(wb_rd), 32'd12);
    tick();
    check("lhu_fast.idle", 32'(ex_ready), 32'd1);
    $display("txn lhu_fast addr=00000002 latency=2");

    // sh with grant held off for 4 cycles: payload stable for 5 REQ cycles
    present(6'h29, 32'h06, 32'h0000ABCD, 5'd3);
    tick();
    ex_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("sh.req",   32'(mem_req), 32'd1);
      check("sh.we",    32'(mem_we), 32'd1);
      check("sh.addr",  32'(mem_addr), 32'h1);
      check("sh.be",    32'(mem_be), 32'(4'b1100));
      check("sh.wdata", mem_wdata, 32'hABCDABCD);
      check("sh.done_early", 32'(done), 32'd0);
      if (i == 4) mem_gnt = 1'b1;
      tick();
    end
    mem_gnt = 1'b0;
    check("sh.done", 32'(done), 32'd1);
    check("sh.wb",   32'(wb_valid), 32'd0);
    check("sh.req_drop", 32'(mem_req), 32'd0);
    tick();
    check("sh.done_drop", 32'(done), 32'd0);
    $display("txn sh addr=00000006 wdata=ABCDABCD");

    do_bad("lw_misal", 6'h23, 32'h02);
    do_bad("illegal22", 6'h22, 32'h00);
    do_bad("lh_misal", 6'h21, 32'h05);

    // lh that never sees rvalid: err 16 cycles after RESP entry
    present(6'h21, 32'h04, 32'd0, 5'd4);
    tick();
    ex_valid = 1'b0;
    mem_gnt  = 1'b1;
    tick();
    mem_gnt = 1'b0;
    for (int i = 1; i < 16; i++) begin
      tick();
      check("to.err_early", 32'(err), 32'd0);
      check("to.wb", 32'(wb_valid), 32'd0);
    end
    tick();
    check("to.err",   32'(err), 32'd1);
    check("to.wb_end", 32'(wb_valid), 32'd0);
    check("to.ready", 32'(ex_ready), 32'd1);
    tick();
    check("to.err_drop", 32'(err), 32'd0);
    $display("txn lh_timeout err after 16 cycles");
    do_load("lw_after_to", 6'h23, 32'h40, 5'd5, 32'h0BADF00D, 30'h10, 4'b1111, 32'h0BADF00D);

    // reset while waiting in RESP; late rvalid must be ignored
    present(6'h23, 32'h08, 32'd0, 5'd6);
    tick();
    ex_valid = 1'b0;
    mem_gnt  = 1'b1;
    tick();
    mem_gnt = 1'b0;
    reset   = 1'b1;
    tick();
    reset = 1'b0;
    check("rstmid.ready", 32'(ex_ready), 32'd1);
    check("rstmid.req",   32'(mem_req), 32'd0);
    check("rstmid.wb",    32'(wb_valid), 32'd0);
    check("rstmid.err",   32'(err), 32'd0);
    check("rstmid.done",  32'(done), 32'd0);
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h12345678;
    tick();
    mem_rvalid = 1'b0;
    check("rstmid.late_wb",   32'(wb_valid), 32'd0);
    check("rstmid.late_done", 32'(done), 32'd0);
    tick();
    check("rstmid.late_wb2",  32'(wb_valid), 32'd0);
    $display("txn reset_in_resp dropped");

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
